aes128_inv_key_sched: RTL and testbench
=======================================

// Module: aes128_inv_key_sched
// PURPOSE
// Iterative AES-128 inverse key scheduler for the decryption datapath. Loads the last
// round key (round NR) and streams round keys NR, NR-1, ..., 0 (cipher key last), one
// per accepted beat. It runs the forward one-round expansion backwards, so the decryptor
// never stores all 11 round keys.
// PARAMETERS
// NR      10   number of rounds; round counter width is 4 bits (fixed for AES-128)
// PORTS
// clk        in   1     clock, all state updates on rising edge
// rst_n      in   1     asynchronous active-low reset
// flush      in   1     synchronous abort; drop the current sequence
// in_valid   in   1     in_key holds a round-NR key to load
// in_ready   out  1     loader can accept in_key this cycle
// in_key     in   128   round-NR key, [0:127], same row-major byte layout as round keys
// out_valid  out  1     out_key/out_round are valid
// out_ready  in   1     consumer accepts the current beat
// out_key    out  128   round key for round out_round, [0:127] row-major
// out_round  out  4     round index of out_key, NR down to 0
// out_last   out  1     high when out_round == 0 (cipher key beat)
// BEHAVIOUR
// - Byte layout: column j (j=0..3) = {k[8j+:8], k[32+8j+:8], k[64+8j+:8], k[96+8j+:8]}.
//   Identical to the forward round-key layout; out_key is bit-compatible with it.
// - Inverse step, round key r -> r-1 (w0..w3 = columns of key r):
//   w3' = w3^w2; w2' = w2^w1; w1' = w1^w0;
//   w0' = w0 ^ SubWord(RotWord(w3')) ^ rcon(r), rcon(1..10) = 01,02,04,..,80,1b,36 <<24.
//   RotWord moves byte 0 to byte 3. SubWord uses the shared S_Box.
// - Reset: state=IDLE, out_valid=0, out_last=0, out_round=0, out_key=0, in_ready=1.
// - FSM IDLE: in_ready=1, out_valid=0. in_valid&in_ready -> key_q<=in_key, round_q<=NR, RUN.
// - FSM RUN: out_valid=1, out_key=key_q, out_round=round_q.
//   On out_valid&out_ready with round_q>0: key_q<=step(key_q,round_q), round_q<=round_q-1.
//   On out_valid&out_ready with round_q==0 (out_last): go to IDLE.
//   No handshake: key_q/round_q hold, outputs stable (AXI-style, no retraction).
// - Latency: first beat (round NR) visible the cycle after load. Then one beat per cycle
//   under continuous out_ready. A full sequence takes NR+1 beats.
// - Back-to-back: in_ready = IDLE | (out_last & out_ready). A load coinciding with the
//   final handshake starts the next sequence with no idle cycle.
// - in_valid while busy and not on the final handshake: ignored (in_ready=0), no key capture.
// - flush: next cycle state=IDLE, out_valid=0. Has priority over in_valid and out handshake
//   in the same cycle. The in_key offered that cycle is not captured.
// - rst_n low mid-sequence: immediate return to reset values; the partial sequence is lost.
// - round_q never wraps below 0. rcon(0) is never used.
// STRUCTURE
// - Rcon_pkg: add function rcon(input [3:0] r) returning the [0:31] word for r=1..10, and 0 otherwise.
// - SBox_pkg: reuse S_Box unchanged.
// - Sub-module aes128_inv_key_step: combinational (key_in[0:127], round[3:0]) -> key_out.
//   Implements the inverse step above; instantiated once in this block.
// TESTING
// - FIPS-197 A.1: load round-10 key cols d014f9a8,c9ee2589,e13f0cc8,b6630ca6.
//   Expect round 9 = ac7766f3,19fadc21,28d12941,575c006e.
// - Same run: round 1 = a0fafe17,88542cb1,23a33939,2a6c7605. Round 0 = 2b7e1516,28aed2a6,abf71588,09cf4f3c.
//   out_last is high only on the round-0 beat. 11 beats in 11 cycles with out_ready=1.
// - Backpressure: drop out_ready randomly. out_key/out_round stay stable while stalled, and the sequence matches the first test.
// - Back-to-back: hold in_valid with the next key during the final beat. The next round-10 beat appears the following cycle, with no gap.
// - flush at round 5 plus a simultaneous in_valid: out_valid=0 next cycle and no capture. A later load restarts at round 10.
// - Async rst_n pulse mid-run, asserted between clock edges: outputs go to reset values immediately. Cross-check against the forward KeyExpansion chain for 100 random keys.

Source files
------------

// File: rtl/aes128_inv_key_sched_pkg.sv
// rtl/aes128_inv_key_sched_pkg.sv - shared types, S-box and rcon helpers for the inverse key scheduler
package aes128_inv_key_sched_pkg;

  localparam logic [3:0] NR = 4'd10;

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  localparam logic [0:2047] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[{b, 3'b000} +: 8];
  endfunction

  // Byte 0 of the word sits in bits [31:24]; rounds outside 1..10 give zero.
  function automatic logic [31:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    rcon = 32'h0100_0000;
      4'd2:    rcon = 32'h0200_0000;
      4'd3:    rcon = 32'h0400_0000;
      4'd4:    rcon = 32'h0800_0000;
      4'd5:    rcon = 32'h1000_0000;
      4'd6:    rcon = 32'h2000_0000;
      4'd7:    rcon = 32'h4000_0000;
      4'd8:    rcon = 32'h8000_0000;
      4'd9:    rcon = 32'h1b00_0000;
      4'd10:   rcon = 32'h3600_0000;
      default: rcon = 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/aes128_inv_key_step.sv
// rtl/aes128_inv_key_step.sv - combinational round key r -> r-1 (forward expansion run backwards)
module aes128_inv_key_step
  import aes128_inv_key_sched_pkg::*;
(
  input  logic [0:127] i_key,
  input  logic [3:0]   i_round,
  output logic [0:127] o_key
);

  logic [31:0] w_col [4];
  logic [31:0] w_new [4];
  logic [31:0] w_rot;
  logic [31:0] w_sub;

  always_comb begin
    for (int j = 0; j < 4; j++) begin
      w_col[j] = {i_key[8*j +: 8], i_key[32+8*j +: 8], i_key[64+8*j +: 8], i_key[96+8*j +: 8]};
    end
    w_new[3] = w_col[3] ^ w_col[2];
    w_new[2] = w_col[2] ^ w_col[1];
    w_new[1] = w_col[1] ^ w_col[0];
    // The recovered w3 of key r-1 feeds the g() function that produced w0 of key r.
    w_rot    = {w_new[3][23:0], w_new[3][31:24]};
    w_sub    = {sbox(w_rot[31:24]), sbox(w_rot[23:16]), sbox(w_rot[15:8]), sbox(w_rot[7:0])};
    w_new[0] = w_col[0] ^ w_sub ^ rcon(i_round);
  end

  always_comb begin
    o_key = '0;
    for (int j = 0; j < 4; j++) begin
      o_key[8*j +: 8]    = w_new[j][31:24];
      o_key[32+8*j +: 8] = w_new[j][23:16];
      o_key[64+8*j +: 8] = w_new[j][15:8];
      o_key[96+8*j +: 8] = w_new[j][7:0];
    end
  end

endmodule

// File: rtl/aes128_inv_key_sched.sv
// rtl/aes128_inv_key_sched.sv - iterative AES-128 inverse key scheduler, streams round keys NR..0
module aes128_inv_key_sched
  import aes128_inv_key_sched_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] out_key,
  output logic [3:0]   out_round,
  output logic         out_last
);

  state_t       r_state;
  logic [0:127] r_key;
  logic [3:0]   r_round;
  logic         r_valid;
  logic         r_last;
  logic [0:127] w_prev_key;

  aes128_inv_key_step u_step (
    .i_key   (r_key),
    .i_round (r_round),
    .o_key   (w_prev_key)
  );

  // r_last is only ever set in RUN, so this also covers the final-handshake reload.
  assign in_ready  = (r_state == ST_IDLE) | (r_last & out_ready);
  assign out_valid = r_valid;
  assign out_key   = r_key;
  assign out_round = r_round;
  assign out_last  = r_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_key   <= '0;
      r_round <= 4'd0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else if (flush) begin
      r_state <= ST_IDLE;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_key   <= in_key;
            r_round <= NR;
            r_valid <= 1'b1;
            r_last  <= 1'b0;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (out_ready) begin
            if (r_round != 4'd0) begin
              r_key   <= w_prev_key;
              r_round <= r_round - 4'd1;
              r_last  <= (r_round == 4'd1);
            end else if (in_valid) begin
              r_key   <= in_key;
              r_round <= NR;
              r_last  <= 1'b0;
            end else begin
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes128_inv_key_sched.sv
// tb/tb_aes128_inv_key_sched.sv - directed self-checking bench for aes128_inv_key_sched
module tb_aes128_inv_key_sched;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [0:127] in_key = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [0:127] out_key;
  logic [3:0]   out_round;
  logic         out_last;

  int checks = 0;
  int failures = 0;

  logic [0:127] rk [11];
  logic [7:0]   rcon_b [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  localparam logic [0:2047] TB_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  aes128_inv_key_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_key    (in_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_key   (out_key),
    .out_round (out_round),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] sb(input logic [7:0] x);
    return TB_SBOX[{x, 3'b000} +: 8];
  endfunction

  function automatic logic [0:127] cols2key(input logic [31:0] c0, input logic [31:0] c1,
                                            input logic [31:0] c2, input logic [31:0] c3);
    logic [0:127] k;
    logic [31:0]  c [4];
    c[0] = c0; c[1] = c1; c[2] = c2; c[3] = c3;
    for (int j = 0; j < 4; j++)
      for (int b = 0; b < 4; b++)
        k[32*b + 8*j +: 8] = c[j][31-8*b -: 8];
    return k;
  endfunction

  // Forward FIPS-197 KeyExpansion; fills rk[0..10].
  task automatic expand(input logic [0:127] ck);
    logic [31:0] w [44];
    logic [31:0] t;
    for (int j = 0; j < 4; j++)
      w[j] = {ck[8*j +: 8], ck[32+8*j +: 8], ck[64+8*j +: 8], ck[96+8*j +: 8]};
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb(t[31:24]), sb(t[23:16]), sb(t[15:8]), sb(t[7:0])} ^ {rcon_b[i/4-1], 24'h0};
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++)
      rk[r] = cols2key(w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]);
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic beat_check(input int r);
    chk("beat_valid", {127'd0, out_valid}, 128'd1);
    chk("beat_round", {124'd0, out_round}, r);
    chk("beat_key", out_key, rk[r]);
    chk("beat_last", {127'd0, out_last}, (r == 0) ? 128'd1 : 128'd0);
  endtask

  task automatic load(input logic [0:127] k);
    in_valid = 1'b1;
    in_key   = k;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_stream(input int hi, input int lo);
    out_ready = 1'b1;
    for (int r = hi; r >= lo; r--) begin
      beat_check(r);
      @(negedge clk);
    end
  endtask

  initial begin
    logic [0:127] cipher;
    logic [0:127] k10;
    logic [0:127] ck;
    int  er;
    bit  done;
    bit  rdy;

    cipher = cols2key(32'h2b7e1516, 32'h28aed2a6, 32'habf71588, 32'h09cf4f3c);
    k10    = cols2key(32'hd014f9a8, 32'hc9ee2589, 32'he13f0cc8, 32'hb6630ca6);

    @(negedge clk);
    chk("rst_valid", {127'd0, out_valid}, 128'd0);
    chk("rst_last", {127'd0, out_last}, 128'd0);
    chk("rst_round", {124'd0, out_round}, 128'd0);
    chk("rst_key", out_key, 128'd0);
    chk("rst_in_ready", {127'd0, in_ready}, 128'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // FIPS-197 A.1 with fixed constants; a busy-time load at round 5 must be ignored.
    expand(cipher);
    out_ready = 1'b1;
    load(k10);
    for (int r = 10; r >= 0; r--) begin
      beat_check(r);
      if (r == 10) chk("fips_r10", out_key, k10);
      if (r == 9) chk("fips_r9", out_key, cols2key(32'hac7766f3, 32'h19fadc21, 32'h28d12941, 32'h575c006e));
      if (r == 1) chk("fips_r1", out_key, cols2key(32'ha0fafe17, 32'h88542cb1, 32'h23a33939, 32'h2a6c7605));
      if (r == 0) chk("fips_r0", out_key, cipher);
      if (r == 5) begin
        in_valid = 1'b1;
        in_key   = '1;
        chk("busy_in_ready", {127'd0, in_ready}, 128'd0);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    chk("fips_done_valid", {127'd0, out_valid}, 128'd0);
    chk("fips_done_in_ready", {127'd0, in_ready}, 128'd1);

    // Random backpressure: each beat must hold until accepted.
    load(k10);
    er = 10;
    done = 1'b0;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      beat_check(er);
      rdy = 1'($urandom_range(0, 1));
      out_ready = rdy;
      @(negedge clk);
      if (rdy) begin
        if (er == 0) done = 1'b1;
        else er--;
      end
    end
    chk("bp_completed", {127'd0, done}, 128'd1);
    chk("bp_idle", {127'd0, out_valid}, 128'd0);

    // Back-to-back: next load rides on the final handshake.
    expand(cipher);
    load(k10);
    run_stream(10, 1);
    beat_check(0);
    chk("b2b_in_ready", {127'd0, in_ready}, 128'd1);
    ck = {$urandom(), $urandom(), $urandom(), $urandom()};
    expand(ck);
    load(rk[10]);
    run_stream(10, 0);
    chk("b2b_done", {127'd0, out_valid}, 128'd0);

    // Flush at round 5 beats a simultaneous load.
    expand(cipher);
    load(k10);
    run_stream(10, 6);
    beat_check(5);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_key   = rk[0];
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", {127'd0, out_valid}, 128'd0);
    chk("flush_in_ready", {127'd0, in_ready}, 128'd1);
    @(negedge clk);
    chk("flush_no_capture", {127'd0, out_valid}, 128'd0);
    load(k10);
    run_stream(10, 0);

    // Async reset between clock edges.
    load(k10);
    run_stream(10, 8);
    beat_check(7);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", {127'd0, out_valid}, 128'd0);
    chk("arst_round", {124'd0, out_round}, 128'd0);
    chk("arst_key", out_key, 128'd0);
    chk("arst_last", {127'd0, out_last}, 128'd0);
    chk("arst_in_ready", {127'd0, in_ready}, 128'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_after", {127'd0, out_valid}, 128'd0);

    // Cross-check against forward expansion for random cipher keys.
    for (int n = 0; n < 100; n++) begin
      ck = {$urandom(), $urandom(), $urandom(), $urandom()};
      expand(ck);
      load(rk[10]);
      run_stream(10, 0);
    end
    chk("rand_done", {127'd0, out_valid}, 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
